// File: rtl/uart_fifo_port.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_fifo_port                                               |
// | Description : 8N1 UART transceiver with a CPU-facing RX store. Defining    |
// |               UART_RX_FIFO_EN gives a 2^RX_DEPTH_LOG2-entry RX FIFO;       |
// |               otherwise RX storage is a single holding register.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_fifo_port #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int RX_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart0_wr,
    input  logic       uart0_rd,
    input  logic [7:0] uart_w,
    output logic       uart0_busy,
    output logic       uart0_valid,
    output logic [7:0] uart0_data,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // ---------------- transmitter ----------------
    uart_state_t        r_tx_state, w_tx_state;
    logic [c_CNT_W-1:0] r_tx_cnt, w_tx_cnt;
    logic [2:0]         r_tx_bit, w_tx_bit;
    logic [7:0]         r_tx_shift, w_tx_shift;
    logic               r_txd, w_txd;
    logic               w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == c_BIT_LAST);

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_txd      = 1'b1;
        if (r_tx_state != S_IDLE) begin
            w_tx_cnt = w_tx_tick ? '0 : r_tx_cnt + c_CNT_ONE;
        end
        case (r_tx_state)
            S_IDLE: begin
                if (uart0_wr) begin
                    w_tx_state = S_START;
                    w_tx_shift = uart_w;
                    w_tx_cnt   = '0;
                end
            end
            S_START: begin
                if (w_tx_tick) w_tx_state = S_DATA;
            end
            S_DATA: begin
                if (w_tx_tick) begin
                    w_tx_bit   = r_tx_bit + 3'd1;
                    w_tx_shift = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state = S_STOP;
                end
            end
            default: begin
                if (w_tx_tick) w_tx_state = S_IDLE;
            end
        endcase
        // Line level is derived from the next state so uart_txd is a flop output.
        case (w_tx_state)
            S_START: w_txd = 1'b0;
            S_DATA:  w_txd = w_tx_shift[0];
            default: w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_txd      <= w_txd;
        end
    end

    assign uart_txd   = r_txd;
    assign uart0_busy = (r_tx_state != S_IDLE);

    // ---------------- receiver ----------------
    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    uart_state_t        r_rx_state, w_rx_state;
    logic [c_CNT_W-1:0] r_rx_cnt, w_rx_cnt;
    logic [2:0]         r_rx_bit, w_rx_bit;
    logic [7:0]         r_rx_shift, w_rx_shift;
    logic               r_push, w_rx_push;

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_push  = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state = S_START;
                    w_rx_cnt   = '0;
                end
            end
            S_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt   = '0;
                    w_rx_bit   = '0;
                    w_rx_state = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt = r_rx_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt   = '0;
                    w_rx_shift = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state = S_STOP;
                end else begin
                    w_rx_cnt = r_rx_cnt + c_CNT_ONE;
                end
            end
            default: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt   = '0;
                    w_rx_state = S_IDLE;
                    w_rx_push  = r_rx_sync;
                end else begin
                    w_rx_cnt = r_rx_cnt + c_CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_push     <= 1'b0;
        end else begin
            r_rx_meta  <= uart_rxd;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_push     <= w_rx_push;
        end
    end

    // ---------------- RX storage ----------------
    // r_rx_shift holds the completed byte until the next frame's data phase,
    // so the store can take it directly on the cycle after the stop sample.
    logic                   w_pop, w_push;
    logic [RX_DEPTH_LOG2:0] w_count;

`ifdef UART_RX_FIFO_EN
    localparam int                       c_DEPTH   = 1 << RX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0]   c_FULL    = (RX_DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [RX_DEPTH_LOG2:0]   c_CNT1    = (RX_DEPTH_LOG2 + 1)'(1);
    localparam logic [RX_DEPTH_LOG2-1:0] c_PTR_ONE = RX_DEPTH_LOG2'(1);

    logic [7:0]               r_mem [c_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [RX_DEPTH_LOG2:0]   r_count;

    assign w_pop  = uart0_rd && ((r_count != '0) || r_push);
    assign w_push = r_push && ((r_count != c_FULL) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT1;
            else if (w_pop && !w_push) r_count <= r_count - c_CNT1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    assign w_count    = r_count;
    assign uart0_data = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
`else
    logic       r_hold_full;
    logic [7:0] r_hold_data;

    assign w_pop  = uart0_rd && r_hold_full;
    assign w_push = r_push && (!r_hold_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_hold_full <= w_push || (r_hold_full && !w_pop);
            if (w_push) r_hold_data <= r_rx_shift;
        end
    end

    assign w_count    = {{RX_DEPTH_LOG2{1'b0}}, r_hold_full};
    assign uart0_data = r_hold_full ? r_hold_data : 8'h00;
`endif

    assign uart0_valid = (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_port.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_fifo_port                                            |
// | Description : Randomised self-checking bench for uart_fifo_port against a  |
// |               queue-based reference model of the RX store and TX framing.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_fifo_port;

    localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, uart0_wr, uart0_rd, uart_rxd;
    logic [7:0] uart_w;
    logic       uart0_busy, uart0_valid, uart_txd;
    logic [7:0] uart0_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] model_q[$];

    uart_fifo_port #(
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH_LOG2(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart0_wr   (uart0_wr),
        .uart0_rd   (uart0_rd),
        .uart_w     (uart_w),
        .uart0_busy (uart0_busy),
        .uart0_valid(uart0_valid),
        .uart0_data (uart0_data),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one byte; optionally pulses a 0x55 write k cycles into the frame.
    task automatic tx_frame(input logic [7:0] b, input int inject_at);
        logic [9:0] frame;
        frame    = {1'b1, b, 1'b0};
        uart0_wr = 1'b1;
        uart_w   = b;
        tick();
        uart0_wr = 1'b0;
        uart_w   = 8'($urandom);
        for (int k = 0; k < 10 * CPB; k++) begin
            check_eq("tx_txd", uart_txd, frame[k / CPB]);
            check_eq("tx_busy", uart0_busy, 1'b1);
            if (k == inject_at) begin
                uart0_wr = 1'b1;
                uart_w   = 8'h55;
            end
            tick();
            uart0_wr = 1'b0;
        end
        check_eq("tx_busy_end", uart0_busy, 1'b0);
        check_eq("tx_txd_idle", uart_txd, 1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (CPB) tick();
        end
        uart_rxd = 1'b1;
        repeat (4) tick();
        if (stop_bit && model_q.size() < DEPTH) model_q.push_back(b);
    endtask

    task automatic rx_glitch();
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (2 * CPB) tick();
    endtask

    task automatic cpu_read();
        if (model_q.size() == 0) begin
            check_eq("rd_valid_empty", uart0_valid, 1'b0);
            check_eq("rd_data_empty", uart0_data, 8'h00);
        end else begin
            check_eq("rd_valid", uart0_valid, 1'b1);
            check_eq("rd_data", uart0_data, model_q[0]);
            void'(model_q.pop_front());
        end
        uart0_rd = 1'b1;
        tick();
        uart0_rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        uart0_wr = 1'b0;
        uart0_rd = 1'b0;
        uart_rxd = 1'b1;
        uart_w   = 8'h00;
        repeat (3) tick();
        check_eq("rst_txd", uart_txd, 1'b1);
        check_eq("rst_busy", uart0_busy, 1'b0);
        check_eq("rst_valid", uart0_valid, 1'b0);
        check_eq("rst_data", uart0_data, 8'h00);
        reset = 1'b0;
        tick();

        // Transmit path, including writes dropped while busy.
        tx_frame(8'hA5, -1);
        tx_frame(8'hA5, 30);
        for (int i = 0; i < 4; i++)
            tx_frame(8'($urandom), int'($urandom_range(5, 10 * CPB - 2)));

        // Ordered receive and drain.
        rx_frame(8'h12, 1'b1);
        rx_frame(8'h34, 1'b1);
        rx_frame(8'h56, 1'b1);
        repeat (4) cpu_read();

        // Overflow: more frames than the store can hold.
        for (int i = 0; i < 9; i++) rx_frame(8'(i), 1'b1);
        repeat (DEPTH + 1) cpu_read();

        // Line faults followed by a clean frame.
        rx_glitch();
        check_eq("glitch_valid", uart0_valid, 1'b0);
        rx_frame(8'($urandom), 1'b0);
        check_eq("framing_valid", uart0_valid, 1'b0);
        rx_frame(8'h7E, 1'b1);
        repeat (2) cpu_read();

        // Random frames, stop-bit errors and interleaved reads.
        for (int i = 0; i < 12; i++) begin
            rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
            repeat ($urandom_range(0, 2)) cpu_read();
        end
        repeat (DEPTH + 1) cpu_read();

        // Asynchronous reset mid-TX with received bytes pending.
        rx_frame(8'($urandom), 1'b1);
        rx_frame(8'($urandom), 1'b1);
        uart0_wr = 1'b1;
        uart_w   = 8'h00;
        tick();
        uart0_wr = 1'b0;
        repeat (20) tick();
        check_eq("pre_rst_busy", uart0_busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_txd", uart_txd, 1'b1);
        check_eq("arst_busy", uart0_busy, 1'b0);
        check_eq("arst_valid", uart0_valid, 1'b0);
        check_eq("arst_data", uart0_data, 8'h00);
        model_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_valid", uart0_valid, 1'b0);
        tx_frame(8'h3C, -1);
        rx_frame(8'hC3, 1'b1);
        repeat (2) cpu_read();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_fifo_port.md
# uart_fifo_port

Byte-wide UART transceiver with a receive FIFO that sits directly under the CPU's memory-mapped UART slot: it consumes the processor-side write/read strobes and transmit byte, and produces the busy/valid/data status the I/O read mux returns at UART RX (0x1000) and misc.in (0x2000). It serialises TX bytes as 8N1 on `uart_txd`, deserialises `uart_rxd` into a small FIFO, and exposes the FIFO head to the CPU.

## Interface
- `CLKS_PER_BIT`, 104, clocks per bit period (12 MHz / 115200); must be ≥ 4.
- `RX_DEPTH_LOG2`, 3, log2 of RX FIFO depth (8 entries); only used with `UART_RX_FIFO_EN`.

- `clk` in 1 — single clock; all logic is rising-edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `uart0_wr` in 1 — one-cycle strobe: start transmitting `uart_w`.
- `uart0_rd` in 1 — one-cycle strobe: pop the RX FIFO head.
- `uart_w` in 8 — TX byte, sampled on the `uart0_wr` cycle.
- `uart0_busy` out 1 — transmitter is sending a frame.
- `uart0_valid` out 1 — RX FIFO is non-empty.
- `uart0_data` out 8 — RX FIFO head (show-ahead); 0x00 when empty.
- `uart_rxd` in 1 — serial input, asynchronous to `clk`.
- `uart_txd` out 1 — serial output; idles high.

## Operation
- **Reset values**
  - `uart_txd` = 1, `uart0_busy` = 0, `uart0_valid` = 0, `uart0_data` = 0x00.
  - FIFO pointers, bit counters and baud counters are 0.
  - Both FSMs are in IDLE.
- **TX FSM: IDLE → START → DATA(×8, LSB first) → STOP → IDLE.**
  - Each state lasts exactly `CLKS_PER_BIT` clocks. START drives 0, STOP drives 1.
  - `uart0_wr` in IDLE latches `uart_w` and enters START.
  - `uart0_wr` while busy is ignored: the byte is dropped and the in-flight frame is unaffected.
- **RX front end**
  - Two-flop synchroniser on `uart_rxd`.
  - The FSM uses only the synchronised value; its edge detector compares it with its previous value.
- **RX FSM: IDLE → START → DATA(×8) → STOP → IDLE.**
  - A synchronised 1→0 edge in IDLE enters START.
  - START waits `CLKS_PER_BIT/2` (integer divide), then samples. If it samples 1 (glitch), the FSM returns to IDLE.
  - Each data bit is sampled `CLKS_PER_BIT` clocks after the previous sample.
  - STOP is sampled one bit period after bit 7.
    - Sample 1: push the byte.
    - Sample 0 (framing error): discard the byte and return to IDLE. A new start is recognised only after the line has returned high, because detection is edge-based.
- **FIFO**
  - Push when full drops the new byte; stored bytes are unchanged.
  - `uart0_rd` when empty is ignored.
  - Push and pop in the same cycle both take effect; count is unchanged, including when full or empty-with-push.
  - Pointers wrap modulo depth. Count is `RX_DEPTH_LOG2+1` bits wide.

## Timing
- **`uart0_wr` at edge N**
  - `uart0_busy` and `uart_txd` = 0 from edge N onward (registered).
  - `uart0_busy` drops at edge N + 10·`CLKS_PER_BIT`.
  - A new write is accepted on that cycle.
- **RX latency**
  - The synchroniser adds 2 clocks.
  - The STOP sample occurs 2 + 1 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` clocks after the line falls.
  - `uart0_valid` and `uart0_data` update at the edge following the STOP sample.
- **Pop**
  - `uart0_data` is combinational from the FIFO head, so the CPU samples it during the `uart0_rd` cycle.
  - The next entry (or 0x00 / `uart0_valid` = 0) appears after that edge.
- **Reset mid-frame**
  - `uart_txd` returns to 1 immediately (asynchronous).
  - The partial RX byte and all FIFO contents are lost.

## Configuration
- `UART_RX_FIFO_EN` defined: RX storage is a 2^`RX_DEPTH_LOG2`-entry FIFO, as described above.
- Not defined: RX storage is a single holding register (depth 1).
  - `uart0_valid` = register full.
  - A received byte arriving while full is dropped.
  - Simultaneous pop and push leaves the new byte held.
  - `RX_DEPTH_LOG2` is ignored.

## Test plan
- **TX byte:** `CLKS_PER_BIT`=8, reset then write 0xA5.
  - `uart_txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 clocks.
  - `uart0_busy` high for exactly 80 clocks.
- **Write while busy:** write 0x55 mid-frame.
  - The original frame is unchanged and 0x55 is never sent.
  - `uart0_busy` still drops at 80 clocks.
- **RX 3 bytes** 0x12, 0x34, 0x56 at 8 clocks/bit, then three `uart0_rd` pulses.
  - `uart0_data` reads 0x12, 0x34, 0x56 in order.
  - `uart0_valid` = 0 and `uart0_data` = 0x00 afterward.
- **Overflow:** with the FIFO enabled, send 9 bytes 0x00..0x08 with no reads.
  - Reads return 0x00..0x07; 0x08 is lost.
  - Without the macro, only 0x00 is returned.
- **Line faults:**
  - A 3-clock low glitch on `uart_rxd` pushes nothing.
  - A frame with stop bit = 0 pushes nothing.
  - A following valid 0x7E is received correctly.
- **Async reset mid-TX frame and with 2 bytes queued:**
  - `uart_txd` = 1 and `uart0_busy` = 0 immediately.
  - `uart0_valid` = 0 after reset.
